// File: rtl/control_pkg.sv
// Purpose     : shared types for the core_l0 control sequencer (FSM states, trap causes).
// Latency     : n/a (types and a pure helper only).
// Backpressure: n/a.
// Ports       : none. Imported by control_seq and its sub-modules.
package control_pkg;

   // Encoding is visible on the debug state port, so the values are fixed.
   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_TRAP    = 3'd5,
      ST_HALT    = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_ILLEGAL  = 2'd1,
      CAUSE_MISALIGN = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } cause_t;

   // A jump target is only legal on a 4-byte boundary.
   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/control_seq_wdog.sv
// Purpose     : bus wait-cycle watchdog; flags expiry on the MEM_TIMEOUT-th consecutive waiting cycle.
// Latency     : o_expired is combinational in the cycle the limit is reached.
// Backpressure: none; the caller drops its request and traps when o_expired is seen.
// Ports       : i_clk, i_rst (sync, active high), i_clr (hold count at 0),
//               i_en (request outstanding and ready low this cycle), o_expired.
//               MEM_TIMEOUT=0 removes the counter and ties o_expired low.
module control_seq_wdog #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   generate
      if (MEM_TIMEOUT > 0) begin : g_wdog
         localparam int CW = $clog2(MEM_TIMEOUT + 1);
         logic [CW-1:0] r_cnt;

         always_ff @(posedge i_clk) begin
            if (i_rst || i_clr) begin
               r_cnt <= '0;
            end else if (i_en) begin
               r_cnt <= r_cnt + CW'(1);
            end
         end

         // r_cnt holds the waits already seen; this cycle would be wait number MEM_TIMEOUT.
         // i_en already includes "ready low", so a ready on that same cycle never expires.
         assign o_expired = i_en && (r_cnt == CW'(MEM_TIMEOUT - 1));
      end else begin : g_off
         logic w_unused;
         assign w_unused  = ^{i_clk, i_rst, i_clr, i_en};
         assign o_expired = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/control_seq.sv
// Purpose     : multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for core_l0 with trap, halt and bus watchdog.
// Latency     : 4 cycles per non-memory instruction, 5 + wait cycles per memory instruction.
// Backpressure: imem_req/dmem_req are held until their ready; the watchdog aborts to TRAP after MEM_TIMEOUT waits.
// Ports       : i_clk, i_rst (sync, active high); imem: o_imem_req, o_imem_addr, i_imem_ready, i_imem_rdata;
//               o_instr, o_pc; decoder: i_dec_mem_op, i_dec_rd_we, i_dec_illegal, i_dec_halt;
//               ALU: i_alu_taken, i_alu_target; dmem: o_dmem_req, i_dmem_ready;
//               o_rf_we, o_trap, o_trap_cause, o_halted, o_state.
//               With CONTROL_SEQ_PERF_EN defined: o_cycle_cnt, o_instret_cnt.
module control_seq
   import control_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = 'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC    = 'h0000_0100,
   parameter int              MEM_TIMEOUT = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ready,
   input  logic [31:0]     i_imem_rdata,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_pc,
   input  logic            i_dec_mem_op,
   input  logic            i_dec_rd_we,
   input  logic            i_dec_illegal,
   input  logic            i_dec_halt,
   input  logic            i_alu_taken,
   input  logic [XLEN-1:0] i_alu_target,
   output logic            o_dmem_req,
   input  logic            i_dmem_ready,
   output logic            o_rf_we,
   output logic            o_trap,
   output logic [1:0]      o_trap_cause,
   output logic            o_halted,
   output logic [2:0]      o_state
`ifdef CONTROL_SEQ_PERF_EN
   ,
   output logic [XLEN-1:0] o_cycle_cnt,
   output logic [XLEN-1:0] o_instret_cnt
`endif
);

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_npc;     // pc for WB, resolved from the ALU in EXECUTE
   logic [31:0]     r_instr;
   logic            r_rd_we;   // rd write-enable captured in EXECUTE for a later WB
   logic            r_imem_req;
   logic            r_dmem_req;
   logic            r_rf_we;
   logic            r_trap;
   cause_t          r_cause;
   logic            r_halted;

   logic            w_wd_clr;
   logic            w_wd_en;
   logic            w_expired;

   // Only one request is ever outstanding, so a single counter serves both buses.
   assign w_wd_clr = !(r_imem_req || r_dmem_req);
   assign w_wd_en  = (r_imem_req && !i_imem_ready) || (r_dmem_req && !i_dmem_ready);

   control_seq_wdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wdog (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_FETCH;
         r_pc       <= RESET_PC;
         r_npc      <= RESET_PC;
         r_instr    <= '0;
         r_rd_we    <= 1'b0;
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
         r_rf_we    <= 1'b0;
         r_trap     <= 1'b0;
         r_cause    <= CAUSE_NONE;
         r_halted   <= 1'b0;
      end else begin
         // Pulse outputs last exactly one cycle unless re-armed below.
         r_rf_we <= 1'b0;
         r_trap  <= 1'b0;
         r_cause <= CAUSE_NONE;

         case (r_state)
            ST_FETCH: begin
               if (!r_imem_req) begin
                  // Only reachable straight out of reset: requests are normally
                  // raised on the WB/TRAP edge that enters FETCH.
                  r_imem_req <= 1'b1;
               end else if (i_imem_ready) begin
                  r_instr    <= i_imem_rdata;
                  r_imem_req <= 1'b0;
                  r_state    <= ST_DECODE;
               end else if (w_expired) begin
                  r_imem_req <= 1'b0;
                  r_trap     <= 1'b1;
                  r_cause    <= CAUSE_TIMEOUT;
                  r_state    <= ST_TRAP;
               end
            end

            ST_DECODE: begin
               r_state <= ST_EXECUTE;
            end

            ST_EXECUTE: begin
               r_npc   <= i_alu_taken ? i_alu_target : r_pc + XLEN'(4);
               r_rd_we <= i_dec_rd_we;
               if (i_dec_illegal) begin
                  r_trap  <= 1'b1;
                  r_cause <= CAUSE_ILLEGAL;
                  r_state <= ST_TRAP;
               end else if (i_dec_halt) begin
                  r_halted <= 1'b1;
                  r_state  <= ST_HALT;
               end else if (i_alu_taken && misaligned(i_alu_target[1:0])) begin
                  r_trap  <= 1'b1;
                  r_cause <= CAUSE_MISALIGN;
                  r_state <= ST_TRAP;
               end else if (i_dec_mem_op) begin
                  r_dmem_req <= 1'b1;
                  r_state    <= ST_MEM;
               end else begin
                  r_rf_we <= i_dec_rd_we;
                  r_state <= ST_WB;
               end
            end

            ST_MEM: begin
               if (i_dmem_ready) begin
                  r_dmem_req <= 1'b0;
                  r_rf_we    <= r_rd_we;
                  r_state    <= ST_WB;
               end else if (w_expired) begin
                  r_dmem_req <= 1'b0;
                  r_trap     <= 1'b1;
                  r_cause    <= CAUSE_TIMEOUT;
                  r_state    <= ST_TRAP;
               end
            end

            ST_WB: begin
               r_pc       <= r_npc;
               r_imem_req <= 1'b1;
               r_state    <= ST_FETCH;
            end

            ST_TRAP: begin
               r_pc       <= TRAP_VEC;
               r_imem_req <= 1'b1;
               r_state    <= ST_FETCH;
            end

            ST_HALT: begin
               r_state <= ST_HALT;
            end

            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   assign o_imem_req   = r_imem_req;
   assign o_imem_addr  = r_pc;
   assign o_pc         = r_pc;
   assign o_instr      = r_instr;
   assign o_dmem_req   = r_dmem_req;
   assign o_rf_we      = r_rf_we;
   assign o_trap       = r_trap;
   assign o_trap_cause = r_cause;
   assign o_halted     = r_halted;
   assign o_state      = r_state;

`ifdef CONTROL_SEQ_PERF_EN
   logic [XLEN-1:0] r_cycle_cnt;
   logic [XLEN-1:0] r_instret_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + XLEN'(1);
         if (r_state == ST_WB) begin
            r_instret_cnt <= r_instret_cnt + XLEN'(1);
         end
      end
   end

   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;
`endif

endmodule
